demux_scan: RTL

- Sequential 1-to-16 demultiplexer; the receive-side counterpart of the 16-to-1 select mux.
- Routes a serial bit stream into a 16-bit parallel register, one bit per select value.
- Direct mode: an externally supplied select addresses the target bit.
- Scan mode: an internal counter sweeps select 0..15 and publishes the whole frame atomically, with a one-cycle done pulse.

---
 rtl/demux_scan_pkg.sv | 25 ++
 rtl/demux_scan_if.sv | 26 ++
 rtl/demux_scan_dec.sv | 17 +
 rtl/demux_scan.sv | 95 +++++++++
 4 files changed

// File: rtl/demux_scan_pkg.sv
// Shared constants and encodings for the demux_scan sequential 1-to-16 demultiplexer.
// WIDTH and SEL_W are derived from the mux-tree depth so both sides of the link agree.
package demux_scan_pkg;

  localparam int NUM_LEVELS = 5;
  localparam int WIDTH      = 2 ** (NUM_LEVELS - 1);
  localparam int SEL_W      = NUM_LEVELS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Replace the bits selected by a one-hot mask with a single broadcast bit.
  function automatic logic [WIDTH-1:0] mergeBit(input logic [WIDTH-1:0] base,
                                                input logic [WIDTH-1:0] hot,
                                                input logic bitVal);
    return (base & ~hot) | (hot & {WIDTH{bitVal}});
  endfunction

endpackage

// File: rtl/demux_scan_if.sv
// Signal bundle between a serial bit source and the demux_scan receiver.
// The slave modport is the receiver's view; master is the driver's view.
interface demux_scan_if;
  import demux_scan_pkg::*;

  logic             in;
  logic             valid;
  logic [SEL_W-1:0] sel;
  logic             mode;
  logic             start;
  logic [WIDTH-1:0] out;
  logic [SEL_W-1:0] sel_out;
  logic             busy;
  logic             frame_done;

  modport slave (
    input  in, valid, sel, mode, start,
    output out, sel_out, busy, frame_done
  );

  modport master (
    output in, valid, sel, mode, start,
    input  out, sel_out, busy, frame_done
  );

endinterface

// File: rtl/demux_scan_dec.sv
// Enable-qualified SEL_W-to-WIDTH one-hot decoder; all-zero when disabled.
module demux_dec
  import demux_scan_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] idx_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_scan.sv
// Sequential 1-to-16 demultiplexer: direct per-bit writes, or a counter-driven scan
// that collects a full frame in a shadow register and publishes it atomically.
module demux_scan
  import demux_scan_pkg::*;
(
  input logic         clk,
  input logic         rst,
  demux_scan_if.slave bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic             dirEn, scanEn;
  logic [WIDTH-1:0] dirHot, scanHot;

  // Direct writes only happen from IDLE, so a scan can never corrupt out mid-frame.
  assign dirEn  = (state_q == IDLE) && (bus.mode == MODE_DIRECT) && bus.valid;
  assign scanEn = (state_q == SCAN) && bus.valid;

  demux_dec u_dirDec (
    .en_i     (dirEn),
    .idx_i    (bus.sel),
    .onehot_o (dirHot)
  );

  demux_dec u_scanDec (
    .en_i     (scanEn),
    .idx_i    (cnt_q),
    .onehot_o (scanHot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    out_d    = out_q;

    case (state_q)
      IDLE: begin
        if (bus.mode == MODE_SCAN) begin
          if (bus.start) begin
            state_d  = SCAN;
            cnt_d    = '0;
            shadow_d = '0;
          end
        end else begin
          out_d = mergeBit(out_q, dirHot, bus.in);
        end
      end

      SCAN: begin
        if (bus.valid) begin
          shadow_d = mergeBit(shadow_q, scanHot, bus.in);
          cnt_d    = cnt_q + SEL_W'(1);
          // Last index: publish including the bit arriving on this very edge.
          if (cnt_q == SEL_W'(WIDTH - 1)) begin
            out_d   = shadow_d;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out        = out_q;
  assign bus.sel_out    = cnt_q;
  assign bus.busy       = (state_q == SCAN);
  assign bus.frame_done = (state_q == DONE);

endmodule
